// File: rtl/gray_ptr_gen_if.sv
// Writer-side bus of the Gray pointer generator: push handshake, write address and pointer exports.
// The almost_full wire exists only when GRAY_PTR_ALMOST_FULL_EN is defined.
interface gray_ptr_gen_if #(
   parameter int ADDR_WIDTH = 4
);
   localparam int PTR_W = ADDR_WIDTH + 1;

   logic                  inc;
   logic [PTR_W-1:0]      sync_gray_ptr;
   logic                  push_ok;
   logic [ADDR_WIDTH-1:0] addr;
   logic [PTR_W-1:0]      gray_ptr;
   logic                  full;
`ifdef GRAY_PTR_ALMOST_FULL_EN
   logic                  almost_full;
`endif

   // The writer and the synchronizer drive the requests; the pointer generator answers them.
   modport master (
      output inc,
      output sync_gray_ptr,
      input  push_ok,
      input  addr,
      input  gray_ptr,
`ifdef GRAY_PTR_ALMOST_FULL_EN
      input  almost_full,
`endif
      input  full
   );

   modport slave (
      input  inc,
      input  sync_gray_ptr,
      output push_ok,
      output addr,
      output gray_ptr,
`ifdef GRAY_PTR_ALMOST_FULL_EN
      output almost_full,
`endif
      output full
   );
endinterface

// File: rtl/gray_ptr_gen.sv
// Write-side pointer generator for an async FIFO: binary address, registered Gray export, registered full.
// Optional registered almost_full output is enabled by defining GRAY_PTR_ALMOST_FULL_EN.
module gray_ptr_gen #(
   parameter int ADDR_WIDTH = 4
) (
   input logic          clk,
   input logic          rst,
   gray_ptr_gen_if.slave bus
);
   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0] bin;
   logic [PTR_W-1:0] bin_next;
   logic [PTR_W-1:0] gray_q;
   logic [PTR_W-1:0] gray_next;
   logic [PTR_W-1:0] full_target;
   logic             full_q;

   assign bus.push_ok = bus.inc & ~full_q;

   // Full when our next Gray pointer equals the reader's with the top two bits inverted,
   // i.e. exactly one lap ahead; the freshly sampled sync pointer is always used.
   always_comb begin
      bin_next    = bin + {{(PTR_W-1){1'b0}}, bus.push_ok};
      gray_next   = bin_next ^ (bin_next >> 1);
      full_target = {~bus.sync_gray_ptr[PTR_W-1:PTR_W-2], bus.sync_gray_ptr[PTR_W-3:0]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin    <= '0;
         gray_q <= '0;
         full_q <= 1'b0;
      end else begin
         bin    <= bin_next;
         gray_q <= gray_next;
         full_q <= (gray_next == full_target);
      end
   end

   assign bus.addr     = bin[ADDR_WIDTH-1:0];
   assign bus.gray_ptr = gray_q;
   assign bus.full     = full_q;

`ifdef GRAY_PTR_ALMOST_FULL_EN
   localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'((2 ** ADDR_WIDTH) - 1);

   logic [PTR_W-1:0] sync_bin;
   logic [PTR_W-1:0] fill_next;
   logic             af_q;

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      sync_bin = '0;
      for (int i = 0; i < PTR_W; i++) begin
         sync_bin[i] = ^(bus.sync_gray_ptr >> i);
      end
      fill_next = bin_next - sync_bin;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         af_q <= 1'b0;
      end else begin
         af_q <= (fill_next >= AF_LEVEL);
      end
   end

   assign bus.almost_full = af_q;
`endif

   // The exported pointer moves by exactly one bit per accepted push and holds otherwise.
   property p_gray_step;
      @(posedge clk) disable iff (!rst)
         $past(rst) |-> ($past(bus.push_ok) ? ($countones(gray_q ^ $past(gray_q)) == 1)
                                            : (gray_q == $past(gray_q)));
   endproperty
   a_gray_step: assert property (p_gray_step);

endmodule

// File: tb/tb_gray_ptr_gen.sv
// Scoreboard bench for gray_ptr_gen (ADDR_WIDTH=4): directed vectors push expectations, a monitor checks them.
module tb_gray_ptr_gen;
   typedef struct {
      string      name;
      logic [3:0] addr;
      logic [4:0] gray;
      logic       full;
      logic       pushOk;
      logic       af;
   } expT;

   logic clk;
   logic rst;
   expT  expQ [$];
   int   assertCount;
   int   failCount;
   logic [4:0] grayTab [32];

   gray_ptr_gen_if #(.ADDR_WIDTH(4)) bus ();

   gray_ptr_gen #(.ADDR_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Inputs change just after the falling edge; the expectation describes the state seen at the next falling edge.
   task automatic applyStimulus(input logic rstVal, input logic incVal, input logic [4:0] syncVal,
                                input string name, input logic [3:0] expAddr, input logic [4:0] expGray,
                                input logic expFull, input logic expPushOk, input logic expAf);
      expT e;
      @(negedge clk);
      #1;
      rst               = rstVal;
      bus.inc           = incVal;
      bus.sync_gray_ptr = syncVal;
      e.name   = name;
      e.addr   = expAddr;
      e.gray   = expGray;
      e.full   = expFull;
      e.pushOk = expPushOk;
      e.af     = expAf;
      expQ.push_back(e);
   endtask

   // Reset dropped between clock edges; the next sample arrives before any further rising edge.
   task automatic resetMidCycle();
      expT e;
      @(negedge clk);
      #1;
      bus.inc = 1'b0;
      @(posedge clk);
      #2;
      rst      = 1'b0;
      e.name   = "async_reset";
      e.addr   = 4'd0;
      e.gray   = 5'd0;
      e.full   = 1'b0;
      e.pushOk = 1'b0;
      e.af     = 1'b0;
      expQ.push_back(e);
   endtask

   // Monitor: every falling edge with a pending expectation is compared against the live outputs.
   initial begin
      expT e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.name, ".addr"},    32'(bus.addr),     32'(e.addr));
            checkOutput({e.name, ".gray"},    32'(bus.gray_ptr), 32'(e.gray));
            checkOutput({e.name, ".full"},    32'(bus.full),     32'(e.full));
            checkOutput({e.name, ".push_ok"}, 32'(bus.push_ok),  32'(e.pushOk));
`ifdef GRAY_PTR_ALMOST_FULL_EN
            checkOutput({e.name, ".almost_full"}, 32'(bus.almost_full), 32'(e.af));
`endif
         end
      end
   end

   initial begin
      grayTab = '{5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04,
                  5'h0C, 5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08,
                  5'h18, 5'h19, 5'h1B, 5'h1A, 5'h1E, 5'h1F, 5'h1D, 5'h1C,
                  5'h14, 5'h15, 5'h17, 5'h16, 5'h12, 5'h13, 5'h11, 5'h10};
      assertCount       = 0;
      failCount         = 0;
      rst               = 1'b0;
      bus.inc           = 1'b1;
      bus.sync_gray_ptr = 5'd0;

      applyStimulus(1'b0, 1'b1, 5'h00, "reset_hold", 4'd0, 5'h00, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 5'h00, "reset_hold", 4'd0, 5'h00, 1'b0, 1'b1, 1'b0);

      // Fill from empty against a stationary reader, with one idle cycle in the middle.
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(1'b1, 1'b1, 5'h00, "fill", 4'(k), grayTab[k],
                       (k == 16), (k != 16), (k >= 15));
         if (k == 8) begin
            applyStimulus(1'b1, 1'b0, 5'h00, "idle_hold", 4'd8, grayTab[8], 1'b0, 1'b0, 1'b0);
         end
      end

      repeat (3) applyStimulus(1'b1, 1'b1, 5'h00, "push_full", 4'd0, 5'h18, 1'b1, 1'b0, 1'b1);

      applyStimulus(1'b1, 1'b0, 5'h01, "release", 4'd0, 5'h18, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 5'h01, "refill",  4'd1, 5'h19, 1'b1, 1'b0, 1'b1);

      // Reader catches up to bin 17; writer then runs through the top of the range and wraps.
      applyStimulus(1'b1, 1'b1, 5'h19, "sync_catchup", 4'd1, 5'h19, 1'b0, 1'b1, 1'b0);
      for (int k = 18; k <= 31; k++) begin
         applyStimulus(1'b1, 1'b1, 5'h19, "wrap_up", 4'(k % 16), grayTab[k], 1'b0, 1'b1, 1'b0);
      end
      applyStimulus(1'b1, 1'b1, 5'h19, "wrap_zero", 4'd0, 5'h00, 1'b0, 1'b1, 1'b1);

      // Reader advances on the same edge as a push: full must use the new sync value.
      applyStimulus(1'b1, 1'b1, 5'h1B, "sync_same_cycle", 4'd1, 5'h01, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 5'h1B, "full_after_wrap", 4'd2, 5'h03, 1'b1, 1'b0, 1'b1);

      applyStimulus(1'b0, 1'b0, 5'h00, "reset_again", 4'd0, 5'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1'b1, 1'b1, 5'h00, "refill_after_reset", 4'(k), grayTab[k], 1'b0, 1'b1, 1'b0);
      end
      resetMidCycle();
      applyStimulus(1'b0, 1'b1, 5'h00, "reset_hold_inc", 4'd0, 5'h00, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 5'h00, "first_push_after_reset", 4'd1, 5'h01, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 5'h00, "idle_after_reset", 4'd1, 5'h01, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      checkOutput("scoreboard_drain", 32'(expQ.size()), 32'd0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule

// File: doc/gray_ptr_gen.md
GRAY_PTR_GEN -- requirements
Module: gray_ptr_gen

Parameters
REQ-001 The module SHALL take ADDR_WIDTH, default 4 (from the DataTypes package): memory address bits; depth is 2^ADDR_WIDTH.
REQ-002 The module SHALL use an internal pointer width of PTR_W = ADDR_WIDTH+1 bits (one wrap bit above the address).

Interface
REQ-003 The port list SHALL be:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- inc, input, 1: push request from the writer.
- sync_gray_ptr, input, PTR_W: reader's Gray pointer, already synchronized into the clk domain.
- push_ok, output, 1: inc accepted this cycle.
- addr, output, ADDR_WIDTH: binary write address for the memory.
- gray_ptr, output, PTR_W: registered Gray-coded pointer, exported to the reader domain.
- full, output, 1: registered FIFO-full flag.
- almost_full, output, 1: present only per REQ-017.

Function
REQ-004 push_ok SHALL be combinational: push_ok = inc & ~full.
REQ-005 The internal binary pointer bin (PTR_W bits) SHALL increment by 1 on each rising edge where push_ok=1, and hold otherwise.
REQ-006 bin SHALL wrap modulo 2^PTR_W (for example all-ones -> 0) with no error indication.
REQ-007 addr SHALL equal bin[ADDR_WIDTH-1:0], so addr wraps every 2^ADDR_WIDTH pushes.
REQ-008 gray_ptr SHALL be registered: gray_ptr <= bin_next ^ (bin_next >> 1), where bin_next is the value bin takes on the same edge.
REQ-009 gray_ptr SHALL never be derived combinationally from bin at the output, and SHALL change by exactly one bit per accepted push.
REQ-010 full SHALL be registered: full <= (gray_next == {~sync_gray_ptr[PTR_W-1:PTR_W-2], sync_gray_ptr[PTR_W-3:0]}).
REQ-011 Latency: bin, addr, gray_ptr and full SHALL all update on the same edge that accepts a push.
- full SHALL assert on the edge accepting the push that fills the last location.
- full SHALL deassert on the first edge after sync_gray_ptr advances.
REQ-012 While full=1, inc SHALL be ignored; there SHALL be no overflow, and bin and gray_ptr SHALL hold.
REQ-013 Simultaneous events: when inc=1 and sync_gray_ptr changes in the same cycle, the full compare SHALL use the new sync_gray_ptr value and gray_next.
REQ-014 The block SHALL have no state machine beyond the pointer registers; there SHALL be no read-side logic.

Reset
REQ-015 While rst=0, the block SHALL immediately clear bin, addr, gray_ptr and full to 0 (and almost_full to 0 when present), independent of clk.
REQ-016 A reset asserted mid-operation SHALL discard the pointer state.
- After rst deasserts, the first accepted push SHALL write addr 0.

Configuration
REQ-017 With macro GRAY_PTR_ALMOST_FULL_EN defined, the block SHALL add a registered almost_full output.
- The block SHALL convert sync_gray_ptr to binary (prefix XOR from the MSB down).
- almost_full SHALL be 1 when (bin_next - sync_bin) mod 2^PTR_W >= 2^ADDR_WIDTH - 1.
REQ-018 Without GRAY_PTR_ALMOST_FULL_EN, the almost_full port and the conversion logic SHALL be absent; all other behaviour SHALL be identical.

Verification (ADDR_WIDTH=4)
REQ-019 Reset: hold rst=0 with inc=1 -> addr=0, gray_ptr=5'b00000, full=0, push_ok=0 only if full; output values apply before any clk edge.
REQ-020 Fill: hold sync_gray_ptr=0 and apply 16 consecutive inc -> addr goes 0..15 then 0, gray_ptr=5'b11000, full=1 after the 16th edge.
REQ-021 Push while full: continue from REQ-020 with 3 more inc -> push_ok=0, and gray_ptr and addr stay unchanged.
REQ-022 Release: from full, set sync_gray_ptr=5'b00001 -> full=0 one edge later; one inc is accepted, then full=1 again with gray_ptr=5'b11001.
REQ-023 Wrap: advance bin to 31 while keeping sync trailing -> gray_ptr=5'b10000; the next push gives gray_ptr=5'b00000 and addr=0, each step a single bit change.
REQ-024 Macro on: with sync_gray_ptr=0, after 15 pushes almost_full=1 and full=0; after the 16th push both are 1.
REQ-025 Reset mid-fill: pulse rst low after 7 pushes -> all outputs 0 immediately; the next push writes addr=0.
